// File: rtl/cache_refill_unit.sv
// Miss refill engine: one burst read, LINE_WORDS-deep landing FIFO, cache writes.
// Define CRITICAL_WORD_FIRST_EN to start the burst at the missing word.
module cache_refill_unit #(
  parameter int FIFO_WIDTH = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_req,
  input  logic [FIFO_WIDTH-1:0]         miss_addr,
  output logic                          busy,
  output logic                          mem_req,
  output logic [FIFO_WIDTH-1:0]         mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_valid,
  input  logic [FIFO_WIDTH-1:0]         mem_rdata,
  input  logic                          cache_ready,
  output logic                          cache_we,
  output logic [$clog2(LINE_WORDS)-1:0] cache_widx,
  output logic [FIFO_WIDTH-1:0]         cache_wdata,
  output logic [FIFO_WIDTH-1:0]         cache_line_addr,
  output logic                          crit_valid,
  output logic [FIFO_WIDTH-1:0]         crit_data,
  output logic                          done
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int OB = IW + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [FIFO_WIDTH-1:0] line_q;
  logic [FIFO_WIDTH-1:0] maddr_q;
  logic [FIFO_WIDTH-1:0] data_mem [LINE_WORDS];
  logic [IW-1:0]         idx_mem  [LINE_WORDS];
  logic [IW:0]           wr_ptr, rd_ptr, rcv_cnt, occ;
  logic [IW-1:0]         s_q, s_nx;
  logic [FIFO_WIDTH-1:0] maddr_nx;
  logic                  accept, push, empty, head_ok;

  assign accept  = (state == IDLE) && miss_req;
  assign occ     = wr_ptr - rd_ptr;
  assign empty   = (occ == '0);
  // rcv_cnt tops out at LINE_WORDS, so its MSB flags a complete burst
  assign push    = (state == FILL) && mem_valid && !rcv_cnt[IW];
  assign head_ok = (state == FILL) && !empty;

  assign busy            = (state != IDLE);
  assign mem_req         = (state == REQ);
  assign done            = (state == DONE);
  assign mem_addr        = maddr_q;
  assign cache_line_addr = line_q;
  assign cache_we        = head_ok && cache_ready;
  assign cache_widx      = head_ok ? idx_mem[rd_ptr[IW-1:0]] : '0;
  assign cache_wdata     = head_ok ? data_mem[rd_ptr[IW-1:0]] : '0;

`ifdef CRITICAL_WORD_FIRST_EN
  assign s_nx       = miss_addr[OB-1:2];
  assign maddr_nx   = {miss_addr[FIFO_WIDTH-1:2], 2'b00};
  assign crit_valid = cache_we && (cache_widx == s_q);
  assign crit_data  = crit_valid ? cache_wdata : '0;
`else
  logic unused_lo;
  assign unused_lo  = ^miss_addr[OB-1:0];
  assign s_nx       = '0;
  assign maddr_nx   = {miss_addr[FIFO_WIDTH-1:OB], {OB{1'b0}}};
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (miss_req) state_nx = REQ;
      REQ:  if (mem_ack) state_nx = FILL;
      // leave once the last buffered word is being written this cycle
      FILL: if (rcv_cnt[IW] &&
                (empty || (occ == (IW+1)'(1) && cache_we)))
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rcv_cnt <= '0;
      s_q     <= '0;
      line_q  <= '0;
      maddr_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        line_q  <= {miss_addr[FIFO_WIDTH-1:OB], {OB{1'b0}}};
        maddr_q <= maddr_nx;
        s_q     <= s_nx;
        rcv_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rcv_cnt <= rcv_cnt + 1'b1;
      end
      if (cache_we) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr[IW-1:0]] <= mem_rdata;
      idx_mem[wr_ptr[IW-1:0]]  <= s_q + rcv_cnt[IW-1:0];
    end
  end

endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Refill engine on the main-memory-to-cache path; the counterpart of the cache-to-main write-back FIFO. On a cache miss it issues one burst read to main memory, buffers the returned words in an internal LINE_WORDS-deep FIFO (memory cannot be stalled), and writes them into the cache data array one word per cycle under cache backpressure. It signals line completion with a one-cycle `done` pulse.

## Interface
- `FIFO_WIDTH`, 32: data and address width. Word = 4 bytes.
- `LINE_WORDS`, 16: words per cache line. Power of two, 2..64.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `miss_req`  in  1  miss request; sampled only in IDLE.
- `miss_addr`  in  FIFO_WIDTH  byte address of the missing access.
- `busy`  out  1  high in every state except IDLE.
- `mem_req`  out  1  burst read request; held until `mem_ack`.
- `mem_addr`  out  FIFO_WIDTH  burst start byte address.
- `mem_ack`  in  1  memory accepts request.
- `mem_valid`  in  1  one returned word this cycle; no stall path.
- `mem_rdata`  in  FIFO_WIDTH  returned word.
- `cache_ready`  in  1  cache array can accept a write.
- `cache_we`  out  1  write strobe.
- `cache_widx`  out  log2(LINE_WORDS)  word index within the line.
- `cache_wdata`  out  FIFO_WIDTH  write data.
- `cache_line_addr`  out  FIFO_WIDTH  line-aligned address of the line being filled.
- `crit_valid`  out  1  critical word delivered (see Configuration).
- `crit_data`  out  FIFO_WIDTH  critical word.
- `done`  out  1  one-cycle pulse: whole line written.

## Operation
- States: IDLE, REQ, FILL, DONE.
- IDLE: when `miss_req`=1, latch `cache_line_addr` = `miss_addr` with the low log2(LINE_WORDS)+2 bits cleared. Latch start index s (0, or the miss word index with the macro). Go to REQ.
- REQ: `mem_req`=1 and `mem_addr` stable. On `mem_ack`=1, go to FILL. `mem_valid` is ignored in REQ.
- FILL:
  - Each `mem_valid` pushes {index, `mem_rdata`} into the FIFO. Index starts at s and increments modulo LINE_WORDS.
  - Words beyond LINE_WORDS received are dropped.
- Drain: `cache_we` = FILL & FIFO non-empty & `cache_ready` (combinational). `cache_widx` and `cache_wdata` show the FIFO head. The head is popped when `cache_we`=1.
- Simultaneous push and pop: occupancy is unchanged. Occupancy is 0..LINE_WORDS and never overflows.
- FILL ends when received count = LINE_WORDS, the FIFO is empty, and there is no pending write. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `miss_req` is ignored while `busy`.
- Reset values:
  - All outputs 0; state IDLE.
  - FIFO pointers and received count 0; s = 0.
- Reset mid-operation: the burst is abandoned and the FIFO is cleared. Later `mem_valid` beats are ignored in IDLE.

## Timing
- `miss_req` sampled at edge 0 → `mem_req`=1 from cycle 1.
- `mem_ack` in cycle k → FILL from cycle k+1.
- A word pushed at edge n is visible at the FIFO head (and can be written) in cycle n+1.
- Zero-stall case (ack in cycle 1, `mem_valid` on cycles 2..L+1, `cache_ready`=1):
  - Writes occur on cycles 3..L+2.
  - `done` occurs in cycle L+3.
- `busy` drops in the cycle after `done`. A new `miss_req` is accepted in that cycle.
- `cache_line_addr` is stable from REQ through DONE.

## Configuration
- `CRITICAL_WORD_FIRST_EN` defined:
  - `mem_addr` = `miss_addr` with the low 2 bits cleared; s = miss word index; indices wrap modulo LINE_WORDS.
  - `crit_valid` pulses for one cycle, coincident with the write of index s, with `crit_data` = that word.
- Not defined:
  - `mem_addr` = `cache_line_addr`; s = 0.
  - `crit_valid` and `crit_data` are tied to 0.

## Test plan
- Basic fill, no macro: LINE_WORDS=16, `miss_addr`=0x0000_1234, ack in cycle 1, `mem_rdata` = 0xA0+i on 16 consecutive beats, `cache_ready`=1.
  - `mem_addr`=0x0000_1200, `cache_line_addr`=0x0000_1200.
  - Writes idx 0..15 with data 0xA0..0xAF on cycles 3..18; `done` in cycle 19.
- Critical word first (macro defined), same stimulus:
  - `mem_addr`=0x0000_1234; write order idx 13,14,15,0,…,12.
  - `crit_valid`=1 only with the idx-13 write, `crit_data`=0xA0.
- Backpressure: `cache_ready`=0 for the entire burst.
  - Occupancy reaches 16 with no data loss.
  - After `cache_ready`=1, 16 writes on consecutive cycles, then `done`.
- Extra beats and ignored request: 18 `mem_valid` beats → only 16 writes.
  - `miss_req`=1 while busy → no second `mem_req` after `done` until `miss_req` is re-sampled in IDLE.
- Reset mid-FILL: `reset` after 5 writes.
  - Next cycle: all outputs 0, `busy`=0.
  - Remaining `mem_valid` beats produce no writes and no `done`.
